// File: rtl/normalize_unit.sv
// Iterative normalizer: finds the leading-zero count of an operand and returns it
// with the left-justified value. Define NORM_SKIP4_EN to shift by 4 when the top nibble is clear.
module normalize_unit #(
  parameter int n = 32,
  parameter int m = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] r,
  output logic [m-1:0] shamt,
  output logic         zero
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state, state_nx;
  logic [n-1:0] work;
  logic [m-1:0] cnt;
  logic         accept, fin_zero, fin_msb, skip4;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (work == '0 || work[n-1]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Completion has priority over shifting; zero test comes before the MSB test.
  always_comb begin
    busy     = (state == RUN);
    accept   = (state == IDLE) && start;
    fin_zero = (state == RUN) && (work == '0);
    fin_msb  = (state == RUN) && (work != '0) && work[n-1];
`ifdef NORM_SKIP4_EN
    // n must be a multiple of 4 in this mode; work is known nonzero here.
    skip4    = (state == RUN) && (work != '0) && (work[n-1 -: 4] == 4'b0);
`else
    skip4    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      r     <= '0;
      shamt <= '0;
      zero  <= 1'b0;
    end else begin
      done <= fin_zero | fin_msb;
      if (accept) begin
        work <= a;
        cnt  <= '0;
      end else if (fin_zero) begin
        zero  <= 1'b1;
        r     <= '0;
        shamt <= '0;
      end else if (fin_msb) begin
        zero  <= 1'b0;
        r     <= work;
        shamt <= cnt;
      end else if (skip4) begin
        work <= work << 4;
        cnt  <= cnt + m'(4);
      end else if (busy) begin
        work <= work << 1;
        cnt  <= cnt + m'(1);
      end
    end
  end

endmodule

// File: tb/tb_normalize_unit.sv
// Self-checking bench for normalize_unit: directed corner cases plus random
// operands checked against an arithmetic leading-zero model.
module tb_normalize_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic        busy, done, zero;
  logic [31:0] r;
  logic [4:0]  shamt;

  int vectors = 0;
  int miscompares = 0;

  normalize_unit #(.n(32), .m(5)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a),
    .busy(busy), .done(done), .r(r), .shamt(shamt), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: leading-zero count by scanning from the MSB.
  function automatic int lz(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
    return 32;
  endfunction

  function automatic int exp_lat(input logic [31:0] v);
    int k;
    k = lz(v);
    if (k == 32) return 1;
`ifdef NORM_SKIP4_EN
    return k / 4 + k % 4 + 1;
`else
    return k + 1;
`endif
  endfunction

  // Issues start in the current cycle (callable inside a done cycle) and checks the result.
  task automatic do_op(input logic [31:0] av, input string nm);
    int k, lat_e, lat, got;
    logic [31:0] r_e;
    k = lz(av);
    lat_e = exp_lat(av);
    r_e = (k == 32) ? 32'h0 : av << k;
    start = 1'b1; a = av;
    tick();
    start = 1'b0; a = $urandom;
    got = 0; lat = 0;
    for (int c = 1; c <= 40 && got == 0; c++) begin
      if (c > 1 || lat_e > 1) begin
        vectors++;
        if (busy !== 1'b1 && c < lat_e) begin
          miscompares++;
          $display("FAIL %s.busy a=%h cyc=%0d got %b want 1", nm, av, c, busy);
        end
      end
      tick();
      if (done === 1'b1) begin got = 1; lat = c; end
    end
    vectors++;
    if (got == 0) begin
      miscompares++;
      $display("FAIL %s.timeout a=%h no done within 40 cycles", nm, av);
    end else begin
      vectors++;
      if (lat != lat_e) begin
        miscompares++;
        $display("FAIL %s.latency a=%h got %0d want %0d", nm, av, lat, lat_e);
      end
      vectors++;
      if (r !== r_e || shamt !== 5'((k == 32) ? 0 : k) || zero !== (k == 32) || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s.result a=%h got r=%h shamt=%0d zero=%b busy=%b want r=%h shamt=%0d zero=%b busy=0",
                 nm, av, r, shamt, zero, busy, r_e, (k == 32) ? 0 : k, k == 32);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    vectors++;
    if (busy !== 0 || done !== 0 || zero !== 0 || r !== 0 || shamt !== 0) begin
      miscompares++;
      $display("FAIL reset.state got busy=%b done=%b zero=%b r=%h shamt=%0d want all 0",
               busy, done, zero, r, shamt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] rh;
    do_op(32'h8000_0000, "dir_msb");
    tick();
    do_op(32'h0000_0001, "dir_one");
    tick();
    do_op(32'h00F0_0000, "dir_f0");
    tick();
    do_op(32'h0000_0000, "dir_zero");
    tick();
    do_op(32'h0001_2345, "dir_mid");
    rh = r;
    tick(); tick(); tick();
    vectors++;
    if (done !== 0 || busy !== 0 || r !== rh || shamt !== 5'd15 || zero !== 0) begin
      miscompares++;
      $display("FAIL dir.hold got done=%b busy=%b r=%h shamt=%0d zero=%b want done=0 busy=0 r=%h shamt=15 zero=0",
               done, busy, r, shamt, zero, rh);
    end
  endtask

  task automatic test_ignore_start();
    int got, lat, lat_e;
    lat_e = exp_lat(32'h1);
    start = 1'b1; a = 32'h1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    start = 1'b1; a = 32'hFFFF_FFFF;
    tick();
    start = 1'b0; a = '0;
    got = 0; lat = 0;
    for (int c = 6; c <= 40 && got == 0; c++) begin
      tick();
      if (done === 1'b1) begin got = 1; lat = c; end
    end
    vectors++;
    if (got == 0 || lat != lat_e || shamt !== 5'd31 || r !== 32'h8000_0000 || zero !== 0) begin
      miscompares++;
      $display("FAIL ignore.result got done=%0d lat=%0d shamt=%0d r=%h want lat=%0d shamt=31 r=80000000",
               got, lat, shamt, r, lat_e);
    end
    tick(); tick();
    vectors++;
    if (busy !== 0 || done !== 0) begin
      miscompares++;
      $display("FAIL ignore.queued got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_rst_mid_run();
    int seen;
    do_op(32'h0000_0300, "pre_rst");
    tick();
    start = 1'b1; a = 32'h1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (busy !== 0 || done !== 0 || zero !== 0 || r !== 0 || shamt !== 0) begin
      miscompares++;
      $display("FAIL rst_mid.state got busy=%b done=%b zero=%b r=%h shamt=%0d want all 0",
               busy, done, zero, r, shamt);
    end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 35; c++) begin tick(); if (done === 1'b1 || busy === 1'b1) seen = 1; end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rst_mid.ghost got activity=%0d want 0", seen);
    end
    do_op(32'h4000_0000, "post_rst");
    tick();
    // rst asserted together with start must win.
    rst = 1'b1; start = 1'b1; a = 32'h1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    vectors++;
    if (busy !== 0 || done !== 0) begin
      miscompares++;
      $display("FAIL rst_start.busy got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av;
    int sh;
    for (int i = 0; i < 40; i++) begin
      sh = $urandom_range(0, 34);
      if (sh >= 32) av = 32'h0;
      else          av = ($urandom | 32'h8000_0000) >> sh;
      do_op(av, "rand");
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_rst_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
